// File: rtl/cp0_pkg.sv
// cp0_pkg: constants shared by the coprocessor-0 block.
//   - CP0 register addresses for mfc0/mtc0
//   - ExcCode values used by the M stage and the CP0
//   - SR / Cause field bit positions
//   - im_mask(): which IM bits exist for a given number of HW interrupt lines
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR / Cause field positions
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int IP_LO_BIT    = 10;
  localparam int IP_HI_BIT    = 15;
  localparam int CAUSE_BD_BIT = 31;
  localparam int EXC_LO_BIT   = 2;

  // Write request forwarded to the timer sub-block
  typedef struct packed {
    logic        count_we;
    logic        compare_we;
    logic [31:0] wdata;
  } timer_wr_t;

  // IM[15:10] implemented-bit mask: bit i (IM[10+i]) exists for i < num_hw;
  // IM[15] always exists because it also carries the timer interrupt.
  function automatic logic [5:0] im_mask(input int num_hw);
    logic [5:0] m;
    m = 6'b100000;
    for (int i = 0; i < 5; i++) begin
      m[i] = m[i] | (i < num_hw);
    end
    return m;
  endfunction

endpackage

// File: rtl/cp0_timer_irq_if.sv
// cp0_timer_irq_if: mfc0/mtc0 access bus of the coprocessor-0 block.
//   we     mtc0 write strobe
//   waddr  mtc0 register address
//   wdata  mtc0 write data
//   raddr  mfc0 register address
//   rdata  mfc0 read data (combinational in the CP0)
// master = pipeline side, slave = CP0 side.
interface cp0_timer_irq_if;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;

  modport master (output we, waddr, wdata, raddr, input rdata);
  modport slave  (input we, waddr, wdata, raddr, output rdata);
endinterface

// File: rtl/cp0_timer_irq_timer.sv
// cp0_timer: prescaler + Count/Compare + sticky timer interrupt flag.
//   clk, reset   clock, synchronous active-high reset
//   wr           gated mtc0 write to Count/Compare (already priority-filtered)
//   count        current Count
//   compare      current Compare
//   timer_irq    sticky Count==Compare flag, cleared by a Compare write
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  timer_wr_t   wr,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_irq
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [31:0]   count_r;
  logic [31:0]   compare_r;
  logic          timer_irq_r;

  // Prescaler and Count: a Count write restarts the prescaler and wins over the tick
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
      count_r <= 32'h0;
    end else if (wr.count_we) begin
      presc_r <= '0;
      count_r <= wr.wdata;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      count_r <= count_r + 32'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Compare register and sticky match flag; a Compare write clears the flag on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      compare_r   <= 32'h0;
      timer_irq_r <= 1'b0;
    end else if (wr.compare_we) begin
      compare_r   <= wr.wdata;
      timer_irq_r <= 1'b0;
    end else if (count_r == compare_r) begin
      timer_irq_r <= 1'b1;
    end
  end

  assign count     = count_r;
  assign compare   = compare_r;
  assign timer_irq = timer_irq_r;

endmodule

// File: rtl/cp0_timer_irq.sv
// cp0_timer_irq: coprocessor 0 for the P7 pipeline (SR, Cause, EPC, Count, Compare, PRId).
//   clk, reset  clock, synchronous active-high reset
//   bus         mfc0/mtc0 access (slave side)
//   m_pc        PC of the M-stage instruction
//   is_bd       M-stage instruction sits in a delay slot
//   exc_code    M-stage exception code, 0 = none
//   hw_int      level-sensitive external interrupt lines
//   exl_clr     eret commit, clears EXL
//   req         take exception/interrupt this cycle (combinational)
//   epc_out     current EPC
//   timer_irq   timer pending flag (Cause[15])
module cp0_timer_irq
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter bit          TIMER_EN   = 1'b1,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] PRID       = 32'h0000_7007
) (
  input  logic                  clk,
  input  logic                  reset,
  cp0_timer_irq_if.slave        bus,
  input  logic [31:0]           m_pc,
  input  logic                  is_bd,
  input  logic [4:0]            exc_code,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exl_clr,
  output logic                  req,
  output logic [31:0]           epc_out,
  output logic                  timer_irq
);

  localparam logic [5:0] IM_MASK = im_mask(NUM_HW_INT);

  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  exc_r;
  logic [31:0] epc_r;

  logic [5:0]  hw_pad_s;
  logic [5:0]  pend_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_raw_s;
  logic        wr_ok_s;
  timer_wr_t   timer_wr_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        timer_irq_s;
  logic [31:0] rdata_s;

  // A sixth HW line shares IP[15] with the timer, as there are only six IP bits.
  assign hw_pad_s  = 6'(hw_int);
  assign pend_s    = {timer_irq_s | hw_pad_s[5], hw_pad_s[4:0]};
  assign int_req_s = (|(pend_s & im_r)) & ie_r & ~exl_r;
  assign exc_req_s = (exc_code != EXC_INT) & ~exl_r;
  assign req_raw_s = int_req_s | exc_req_s;
  assign req       = req_raw_s & ~reset;

  // mtc0 only lands when neither eret nor an exception/interrupt owns the cycle
  assign wr_ok_s = bus.we & ~req_raw_s & ~exl_clr;

  // Decode gated mtc0 writes aimed at the timer
  always_comb begin
    timer_wr_s.count_we   = 1'b0;
    timer_wr_s.compare_we = 1'b0;
    timer_wr_s.wdata      = bus.wdata;
    if (wr_ok_s) begin
      timer_wr_s.count_we   = (bus.waddr == CP0_COUNT);
      timer_wr_s.compare_we = (bus.waddr == CP0_COMPARE);
    end else begin
      timer_wr_s.count_we   = 1'b0;
      timer_wr_s.compare_we = 1'b0;
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .wr        (timer_wr_s),
        .count     (count_s),
        .compare   (compare_s),
        .timer_irq (timer_irq_s)
      );
    end else begin : g_no_timer
      assign count_s     = 32'h0;
      assign compare_s   = 32'h0;
      assign timer_irq_s = 1'b0;
    end
  endgenerate

  // SR/Cause/EPC update: eret > exception/interrupt > mtc0; IP is re-sampled every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      im_r       <= 6'h0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      cause_ip_r <= 6'h0;
      exc_r      <= 5'h0;
      epc_r      <= 32'h0;
    end else begin
      cause_ip_r <= pend_s;
      if (exl_clr) begin
        exl_r <= 1'b0;
      end else if (req_raw_s) begin
        exl_r <= 1'b1;
        bd_r  <= is_bd;
        exc_r <= int_req_s ? EXC_INT : exc_code;
        epc_r <= is_bd ? (m_pc - 32'd4) : m_pc;
      end else if (bus.we) begin
        case (bus.waddr)
          CP0_SR: begin
            im_r  <= bus.wdata[IP_HI_BIT:IP_LO_BIT] & IM_MASK;
            exl_r <= bus.wdata[SR_EXL_BIT];
            ie_r  <= bus.wdata[SR_IE_BIT];
          end
          CP0_EPC: epc_r <= bus.wdata;
          // Cause is hardware-owned; Count/Compare live in the timer
          default: ;
        endcase
      end
    end
  end

  // mfc0 read mux; unimplemented addresses read zero
  always_comb begin
    rdata_s = 32'h0;
    case (bus.raddr)
      CP0_SR:      rdata_s = {16'h0, im_r, 8'h0, exl_r, ie_r};
      CP0_CAUSE:   rdata_s = {bd_r, 15'h0, cause_ip_r, 3'h0, exc_r, 2'h0};
      CP0_EPC:     rdata_s = epc_r;
      CP0_COUNT:   rdata_s = count_s;
      CP0_COMPARE: rdata_s = compare_s;
      CP0_PRID:    rdata_s = PRID;
      default:     rdata_s = 32'h0;
    endcase
  end

  assign bus.rdata = rdata_s;
  assign epc_out   = epc_r;
  assign timer_irq = timer_irq_s;

endmodule
